// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, carry held in a flop.
// Optional subtract mode is compiled in with SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH + 1);
    // Partial-sum register only needs the bits above the one being produced now
    localparam int SW = (WIDTH > 1) ? WIDTH - 1 : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [SW-1:0]    s_sh_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    logic             b_invert;
    logic             carry_init;
    logic [WIDTH-1:0] b_load;
    logic             s_bit;
    logic             c_bit;
    logic [SW-1:0]    s_sh_next;
    logic [WIDTH-1:0] sum_done;

    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (x & ci) | (y & ci);
    endfunction

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert B and force the initial carry to 1
    assign b_invert   = sub;
    assign carry_init = sub | Cin;
`else
    assign b_invert   = 1'b0;
    assign carry_init = Cin;
`endif

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bload
            assign b_load[gi] = B[gi] ^ b_invert;
        end
    endgenerate

    assign s_bit = fa_sum(a_sh_reg[0], b_sh_reg[0], carry_reg);
    assign c_bit = fa_carry(a_sh_reg[0], b_sh_reg[0], carry_reg);

    generate
        if (WIDTH == 1) begin : g_w1
            assign s_sh_next = s_bit;
            assign sum_done  = s_bit;
        end else if (WIDTH == 2) begin : g_w2
            assign s_sh_next = s_bit;
            assign sum_done  = {s_bit, s_sh_reg};
        end else begin : g_wn
            assign s_sh_next = {s_bit, s_sh_reg[SW-1:1]};
            assign sum_done  = {s_bit, s_sh_reg};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            s_sh_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_reg  <= A;
                        b_sh_reg  <= b_load;
                        carry_reg <= carry_init;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_reg  <= a_sh_reg >> 1;
                    b_sh_reg  <= b_sh_reg >> 1;
                    s_sh_reg  <= s_sh_next;
                    carry_reg <= c_bit;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST) begin
                        sum_reg   <= sum_done;
                        cout_reg  <= c_bit;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign Sum  = sum_reg;
    assign Cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for the directed scenarios
// and a 2-bit instance swept exhaustively. Subtract cases need SERIAL_ADDER_SUB_EN.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       sub8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       cin2 = 1'b0;
    logic       sub2 = 1'b0;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] exp8_q[$];
    logic [2:0] exp2_q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .Sum(sum8), .Cout(cout8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2), .Cin(cin2),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub2),
`endif
        .busy(busy2), .done(done2), .Sum(sum2), .Cout(cout2)
    );

    // Reference: add gives A+B+Cin; subtract gives {A>=B, (A-B) mod 256}
    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin, input logic s);
        logic [7:0] d;
        if (s) begin
            d = a - b;
            return {(a >= b), d};
        end
        return {1'b0, a} + {1'b0, b} + {8'd0, cin};
    endfunction

    // Drive one request on the 8-bit DUT; call at a negedge, returns at the next one
    task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                            input logic cin, input logic s);
        a8 = a; b8 = b; cin8 = cin; sub8 = s; start8 = 1'b1;
        exp8_q.push_back(model8(a, b, cin, s));
        @(negedge clk);
        start8 = 1'b0;
        a8 = $urandom; b8 = $urandom; cin8 = $urandom_range(0, 1);
    endtask

    // Waits (bounded) for done on the 8-bit DUT; cycles counts edges since the start edge
    task automatic wait_done8(output int cycles, output int busy_cnt);
        cycles = 0; busy_cnt = 0;
        while (!done8 && cycles < 40) begin
            if (busy8) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic pop_check8(input string name);
        logic [8:0] exp;
        exp = (exp8_q.size() > 0) ? exp8_q.pop_front() : 'x;
        n_vec++;
        if ({cout8, sum8} !== exp) begin
            n_err++;
            $display("FAIL %s: got Cout=%0b Sum=%02h, expected Cout=%0b Sum=%02h",
                     name, cout8, sum8, exp[8], exp[7:0]);
        end else
            $display("vector %s: Cout=%0b Sum=%02h", name, cout8, sum8);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy8); end
        n_vec++; if (done8 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", done8); end
        n_vec++; if (sum8 !== 8'h00) begin n_err++; $display("FAIL reset_sum: got %02h want 00", sum8); end
        n_vec++; if (cout8 !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %0b want 0", cout8); end
        n_vec++; if ({busy2, done2, cout2, sum2} !== 5'd0) begin
            n_err++; $display("FAIL reset_w2: got %05b want 00000", {busy2, done2, cout2, sum2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_zero;
        int cyc, bc;
        start_op(8'h00, 8'h00, 1'b0, 1'b0);
        wait_done8(cyc, bc);
        n_vec++; if (cyc != 8) begin n_err++; $display("FAIL zero_latency: got %0d want 8", cyc); end
        n_vec++; if (bc != 8) begin n_err++; $display("FAIL zero_busy_cycles: got %0d want 8", bc); end
        n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL zero_busy_at_done: got %0b want 0", busy8); end
        pop_check8("zero");
        @(negedge clk);
        n_vec++; if (done8 !== 1'b0) begin n_err++; $display("FAIL zero_done_pulse: got %0b want 0", done8); end
    endtask

    task automatic test_back_to_back;
        int cyc, bc;
        start_op(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done8(cyc, bc);
        n_vec++; if (cyc != 8) begin n_err++; $display("FAIL b2b1_latency: got %0d want 8", cyc); end
        pop_check8("ff_plus_01");
        // Still on the done cycle: the next request must be accepted
        start_op(8'hA5, 8'h5A, 1'b1, 1'b0);
        wait_done8(cyc, bc);
        n_vec++; if (cyc != 8) begin n_err++; $display("FAIL b2b2_latency: got %0d want 8", cyc); end
        pop_check8("a5_plus_5a_c1");
    endtask

    task automatic test_ignore_busy;
        int cyc, bc, extra;
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (2) begin
            n_vec++; if ({cout8, sum8} !== 9'h100) begin
                n_err++; $display("FAIL hold_prev: got %03h want 100", {cout8, sum8});
            end
            @(negedge clk);
        end
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(cyc, bc);
        n_vec++; if (cyc + 3 != 8) begin n_err++; $display("FAIL ignore_latency: got %0d want 8", cyc + 3); end
        pop_check8("12_plus_34");
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) extra++;
        end
        n_vec++; if (extra != 0) begin n_err++; $display("FAIL ignore_extra_done: got %0d want 0", extra); end
    endtask

    task automatic test_reset_mid_run;
        int cyc, bc, spurious;
        start_op(8'h80, 8'h80, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp8_q.delete();
        n_vec++; if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            n_err++; $display("FAIL midrst_clear: got busy=%0b done=%0b Cout=%0b Sum=%02h want all 0",
                              busy8, done8, cout8, sum8);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (10) begin
            @(negedge clk);
            if (done8 || busy8) spurious++;
        end
        n_vec++; if (spurious != 0) begin n_err++; $display("FAIL midrst_no_done: got %0d want 0", spurious); end
        start_op(8'h80, 8'h80, 1'b0, 1'b0);
        wait_done8(cyc, bc);
        n_vec++; if (cyc != 8) begin n_err++; $display("FAIL midrst_latency: got %0d want 8", cyc); end
        pop_check8("80_plus_80");
    endtask

    task automatic test_width2;
        int cyc;
        logic [2:0] exp;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    a2 = a[1:0]; b2 = b[1:0]; cin2 = c[0]; start2 = 1'b1;
                    exp2_q.push_back(3'(a + b + c));
                    @(negedge clk);
                    start2 = 1'b0;
                    cyc = 0;
                    while (!done2 && cyc < 20) begin
                        @(negedge clk);
                        cyc++;
                    end
                    n_vec++; if (cyc != 2) begin
                        n_err++; $display("FAIL w2_latency a=%0d b=%0d c=%0d: got %0d want 2", a, b, c, cyc);
                    end
                    exp = (exp2_q.size() > 0) ? exp2_q.pop_front() : 'x;
                    n_vec++;
                    if ({cout2, sum2} !== exp) begin
                        n_err++; $display("FAIL w2_sum a=%0d b=%0d c=%0d: got %03b want %03b",
                                          a, b, c, {cout2, sum2}, exp);
                    end else
                        $display("vector w2 a=%0d b=%0d c=%0d: {Cout,Sum}=%03b", a, b, c, {cout2, sum2});
                end
            end
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        int cyc, bc;
        start_op(8'h05, 8'h07, 1'b1, 1'b1);
        wait_done8(cyc, bc);
        n_vec++; if (cyc != 8) begin n_err++; $display("FAIL sub1_latency: got %0d want 8", cyc); end
        pop_check8("05_minus_07");
        start_op(8'h07, 8'h05, 1'b0, 1'b1);
        wait_done8(cyc, bc);
        n_vec++; if (cyc != 8) begin n_err++; $display("FAIL sub2_latency: got %0d want 8", cyc); end
        pop_check8("07_minus_05");
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_run();
        test_width2();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
